tff_toggle_arbiter: RTL



---
 rtl/tff_toggle_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/tff_toggle_arbiter.sv
// rtl/tff_toggle_arbiter.sv - round-robin arbiter owning a shared T flip-flop bank
// Optional macro TFF_ARB_FIXED_PRIO_EN: lowest-index fixed priority, no rotating pointer.
module tff_toggle_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   mask,
   output logic [NREQ-1:0]         gnt,
   output logic [WIDTH-1:0]        t,
   output logic [WIDTH-1:0]        q,
   output logic [WIDTH-1:0]        qb,
   output logic                    busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, SETTLE} state_t;

   state_t           state, state_n;
   logic [NREQ-1:0]  gnt_n;
   logic [WIDTH-1:0] t_n, q_n, win_mask;
   logic             found;
   logic [PW-1:0]    win;

`ifdef TFF_ARB_FIXED_PRIO_EN
   // Downward scan so the lowest asserted index is the last one written.
   always_comb begin
      found = |req;
      win   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[k]) win = PW'(k);
      end
   end
`else
   logic [PW-1:0] ptr, ptr_n;
   int            idx;

   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
   end
`endif

   assign win_mask = mask[int'(win)*WIDTH +: WIDTH];
   assign qb       = ~q;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         gnt   <= '0;
         t     <= '0;
         q     <= '0;
`ifndef TFF_ARB_FIXED_PRIO_EN
         ptr   <= '0;
`endif
      end else begin
         state <= state_n;
         gnt   <= gnt_n;
         t     <= t_n;
         q     <= q_n;
`ifndef TFF_ARB_FIXED_PRIO_EN
         ptr   <= ptr_n;
`endif
      end
   end

   // Only the IDLE edge arbitrates; GRANT and SETTLE just sequence out.
   always_comb begin
      state_n = state;
      gnt_n   = '0;
      t_n     = '0;
      q_n     = q;
`ifndef TFF_ARB_FIXED_PRIO_EN
      ptr_n   = ptr;
`endif
      case (state)
         IDLE: begin
            if (found) begin
               state_n    = GRANT;
               gnt_n[win] = 1'b1;
               t_n        = win_mask;
               q_n        = q ^ win_mask;
`ifndef TFF_ARB_FIXED_PRIO_EN
               ptr_n      = PW'((int'(win) + 1) % NREQ);
`endif
            end
         end
         GRANT:   state_n = SETTLE;
         SETTLE:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

endmodule
